// File: rtl/mem_stage_if.sv
// EX -> MEM result bundle, M-stage store-data forwarding inputs, and the M/W and forwarding outputs.
// master = EX/hazard/writeback side, slave = mem_stage.
interface mem_stage_if;
    logic [31:0] IR_E_in;
    logic [31:0] PC8_E_in;
    logic [31:0] ALUOUT_E_in;
    logic [31:0] RT_E_in;
    logic        Forward_RT_M;
    logic [31:0] mux_Wdata_out;

    logic [31:0] ALUOUT_M_out;
    logic [31:0] PC8_M_out;
    logic [31:0] IR_M_out;
    logic [31:0] IR_W;
    logic [31:0] PC8_W;
    logic [31:0] ALUOUT_W;
    logic [31:0] DMOUT_W;
    logic        ADDR_EXC_W;

    modport master (
        output IR_E_in, PC8_E_in, ALUOUT_E_in, RT_E_in, Forward_RT_M, mux_Wdata_out,
        input  ALUOUT_M_out, PC8_M_out, IR_M_out, IR_W, PC8_W, ALUOUT_W, DMOUT_W, ADDR_EXC_W
    );

    modport slave (
        input  IR_E_in, PC8_E_in, ALUOUT_E_in, RT_E_in, Forward_RT_M, mux_Wdata_out,
        output ALUOUT_M_out, PC8_M_out, IR_M_out, IR_W, PC8_W, ALUOUT_W, DMOUT_W, ADDR_EXC_W
    );
endinterface

// File: rtl/mem_stage.sv
// MIPS MEM stage: E/M register, byte-lane data memory, load extension, M/W register.
// Latency: EX->M 1 clk, M->W 1 clk (load data lands in DMOUT_W at the end of the M cycle).
// Backpressure: none, advances every clk; misalignment trap only with ADDR_ALIGN_CHECK_EN defined.
module mem_stage #(
    parameter int DM_ADDR_W = 10
) (
    input  logic       clk,
    input  logic       reset,
    mem_stage_if.slave bus
);
    localparam int DM_DEPTH = 1 << DM_ADDR_W;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SB  = 6'b101000;

    logic [31:0]          ir_m, pc8_m, aluout_m, rt_m;
    logic [31:0]          ir_w, pc8_w, aluout_w, dmout_w;
    logic                 addr_exc_w;

    logic [5:0]           opcode;
    logic [1:0]           byte_off;
    logic [DM_ADDR_W-1:0] word_idx;
    logic [31:0]          sd, rd_word, wr_word, ld_data;
    logic [15:0]          rd_half;
    logic [7:0]           rd_byte;
    logic                 is_store, misaligned, wr_en;
    logic [31:0]          dm [DM_DEPTH];

    assign opcode   = ir_m[31:26];
    assign byte_off = aluout_m[1:0];
    assign word_idx = aluout_m[DM_ADDR_W+1:2];
    assign sd       = bus.Forward_RT_M ? bus.mux_Wdata_out : rt_m;
    assign rd_word  = dm[word_idx];
    assign rd_half  = byte_off[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        rd_byte = rd_word[7:0];
        case (byte_off)
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            2'd3:    rd_byte = rd_word[31:24];
            default: rd_byte = rd_word[7:0];
        endcase
    end

    // Partial stores merge into the current word so untouched lanes are rewritten unchanged.
    always_comb begin
        wr_word  = rd_word;
        is_store = 1'b0;
        case (opcode)
            OP_SW: begin
                is_store = 1'b1;
                wr_word  = sd;
            end
            OP_SH: begin
                is_store = 1'b1;
                if (byte_off[1]) wr_word[31:16] = sd[15:0];
                else             wr_word[15:0]  = sd[15:0];
            end
            OP_SB: begin
                is_store = 1'b1;
                case (byte_off)
                    2'd1:    wr_word[15:8]  = sd[7:0];
                    2'd2:    wr_word[23:16] = sd[7:0];
                    2'd3:    wr_word[31:24] = sd[7:0];
                    default: wr_word[7:0]   = sd[7:0];
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_data = '0;
        case (opcode)
            OP_LW:   ld_data = rd_word;
            OP_LH:   ld_data = {{16{rd_half[15]}}, rd_half};
            OP_LHU:  ld_data = {16'h0000, rd_half};
            OP_LB:   ld_data = {{24{rd_byte[7]}}, rd_byte};
            OP_LBU:  ld_data = {24'h000000, rd_byte};
            default: ld_data = '0;
        endcase
    end

`ifdef ADDR_ALIGN_CHECK_EN
    always_comb begin
        misaligned = 1'b0;
        case (opcode)
            OP_LW, OP_SW:         misaligned = |byte_off;
            OP_LH, OP_LHU, OP_SH: misaligned = byte_off[0];
            default:              misaligned = 1'b0;
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    assign wr_en = is_store & ~misaligned;

    always_ff @(posedge clk) begin
        if (reset) begin
            ir_m       <= '0;
            pc8_m      <= '0;
            aluout_m   <= '0;
            rt_m       <= '0;
            ir_w       <= '0;
            pc8_w      <= '0;
            aluout_w   <= '0;
            dmout_w    <= '0;
            addr_exc_w <= 1'b0;
        end else begin
            ir_m       <= bus.IR_E_in;
            pc8_m      <= bus.PC8_E_in;
            aluout_m   <= bus.ALUOUT_E_in;
            rt_m       <= bus.RT_E_in;
            ir_w       <= ir_m;
            pc8_w      <= pc8_m;
            aluout_w   <= aluout_m;
            dmout_w    <= misaligned ? 32'h0 : ld_data;
            addr_exc_w <= misaligned;
        end
    end

    // One register per word so reset can clear the whole array in a single cycle.
    for (genvar g = 0; g < DM_DEPTH; g++) begin : g_dm
        logic [31:0] word_q;
        always_ff @(posedge clk) begin
            if (reset)
                word_q <= '0;
            else if (wr_en && word_idx == DM_ADDR_W'(g))
                word_q <= wr_word;
        end
        assign dm[g] = word_q;
    end

    assign bus.ALUOUT_M_out = aluout_m;
    assign bus.PC8_M_out    = pc8_m;
    assign bus.IR_M_out     = ir_m;
    assign bus.IR_W         = ir_w;
    assign bus.PC8_W        = pc8_w;
    assign bus.ALUOUT_W     = aluout_w;
    assign bus.DMOUT_W      = dmout_w;
`ifdef ADDR_ALIGN_CHECK_EN
    assign bus.ADDR_EXC_W   = addr_exc_w;
`else
    assign bus.ADDR_EXC_W   = 1'b0;
`endif
endmodule
